// File: rtl/ahb_slave_2_pkg.sv
// Shared definitions for the AES configuration slave: register offsets
// relative to BASE_ADDR, the mode-flag width and its type.
package ahb_slave_2_pkg;

   localparam logic [31:0] OFS_RD_LOC = 32'h0000_0000;
   localparam logic [31:0] OFS_WR_LOC = 32'h0000_0004;
   localparam logic [31:0] OFS_KEY0   = 32'h0000_0008;
   localparam logic [31:0] OFS_KEY1   = 32'h0000_000C;
   localparam logic [31:0] OFS_KEY2   = 32'h0000_0010;
   localparam logic [31:0] OFS_KEY3   = 32'h0000_0014;
   localparam logic [31:0] OFS_SIZE   = 32'h0000_0018;
   localparam logic [31:0] OFS_FLAG   = 32'h0000_001C;

   localparam int FLAG_W = 2;

   typedef logic [FLAG_W-1:0] flag_t;

endpackage

// File: rtl/ahb_slave_2.sv
// AHB-Lite style configuration slave for the AES accelerator.
// Holds source/destination addresses, the 128-bit key, data size and mode
// flag; zero-wait-state single-word transfers with full readback.
// Optional build macro AHB_SLAVE_KEY_READ_MASK_EN makes the key write-only
// from the bus (key offsets read as zero); the key output is unaffected.
module ahb_slave_2
   import ahb_slave_2_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         hclk,
   input  logic         hreset,
   input  logic [31:0]  haddr,
   input  logic         hwrite,
   input  logic         hready,
   input  logic [31:0]  hwdata,
   output logic         hreadyout,
   output logic [31:0]  hrdata,
   output logic [31:0]  data_read_loc,
   output logic [31:0]  data_write_loc,
   output logic [127:0] key,
   output logic [31:0]  size_data,
   output logic [1:0]   flag
);

   logic [31:0]  addr_q,   addr_d;
   logic         write_q,  write_d;
   logic [31:0]  rd_loc_q, rd_loc_d;
   logic [31:0]  wr_loc_q, wr_loc_d;
   logic [127:0] key_q,    key_d;
   logic [31:0]  size_q,   size_d;
   flag_t        flag_q,   flag_d;

   logic [31:0]  ofs_s;
   logic [31:0]  hrdata_s;

   // Full 32-bit offset of the pending transfer; anything outside the
   // eight exact offsets falls to the default arm and is unmapped.
   always_comb begin
      ofs_s = addr_q - BASE_ADDR;
   end

   // Next-state: latch a new address phase and commit the pending write
   // on every hready cycle; address and data phases overlap.
   always_comb begin
      addr_d   = addr_q;
      write_d  = write_q;
      rd_loc_d = rd_loc_q;
      wr_loc_d = wr_loc_q;
      key_d    = key_q;
      size_d   = size_q;
      flag_d   = flag_q;
      if (hready) begin
         addr_d  = haddr;
         write_d = hwrite;
         if (write_q) begin
            case (ofs_s)
               OFS_RD_LOC: rd_loc_d         = hwdata;
               OFS_WR_LOC: wr_loc_d         = hwdata;
               OFS_KEY0:   key_d[127:96]    = hwdata;
               OFS_KEY1:   key_d[95:64]     = hwdata;
               OFS_KEY2:   key_d[63:32]     = hwdata;
               OFS_KEY3:   key_d[31:0]      = hwdata;
               OFS_SIZE:   size_d           = hwdata;
               OFS_FLAG:   flag_d           = hwdata[FLAG_W-1:0];
               default:    rd_loc_d         = rd_loc_q;  // unmapped: write dropped
            endcase
         end else begin
            rd_loc_d = rd_loc_q;  // read data phase: no register change
         end
      end else begin
         addr_d = addr_q;  // bus stalled: hold the pipeline
      end
   end

   // State register; reset wins over everything and drops a pending write.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         addr_q   <= 32'h0;
         write_q  <= 1'b0;
         rd_loc_q <= 32'h0;
         wr_loc_q <= 32'h0;
         key_q    <= 128'h0;
         size_q   <= 32'h0;
         flag_q   <= '0;
      end else begin
         addr_q   <= addr_d;
         write_q  <= write_d;
         rd_loc_q <= rd_loc_d;
         wr_loc_q <= wr_loc_d;
         key_q    <= key_d;
         size_q   <= size_d;
         flag_q   <= flag_d;
      end
   end

   // Combinational read mux for the data phase of a read transfer.
   always_comb begin
      hrdata_s = 32'h0;
      if (!write_q) begin
         case (ofs_s)
            OFS_RD_LOC: hrdata_s = rd_loc_q;
            OFS_WR_LOC: hrdata_s = wr_loc_q;
`ifdef AHB_SLAVE_KEY_READ_MASK_EN
            OFS_KEY0:   hrdata_s = 32'h0;
            OFS_KEY1:   hrdata_s = 32'h0;
            OFS_KEY2:   hrdata_s = 32'h0;
            OFS_KEY3:   hrdata_s = 32'h0;
`else
            OFS_KEY0:   hrdata_s = key_q[127:96];
            OFS_KEY1:   hrdata_s = key_q[95:64];
            OFS_KEY2:   hrdata_s = key_q[63:32];
            OFS_KEY3:   hrdata_s = key_q[31:0];
`endif
            OFS_SIZE:   hrdata_s = size_q;
            OFS_FLAG:   hrdata_s = {{(32-FLAG_W){1'b0}}, flag_q};
            default:    hrdata_s = 32'h0;
         endcase
      end else begin
         hrdata_s = 32'h0;
      end
   end

   assign hreadyout      = 1'b1;
   assign hrdata         = hrdata_s;
   assign data_read_loc  = rd_loc_q;
   assign data_write_loc = wr_loc_q;
   assign key            = key_q;
   assign size_data      = size_q;
   assign flag           = flag_q;

endmodule

// File: tb/tb_ahb_slave_2.sv
// Self-checking bench for ahb_slave_2: directed test-plan sequences with
// literal expectations, then randomized traffic checked every cycle
// against a word-array model of the register block.
module tb_ahb_slave_2;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic         hclk = 1'b0;
   logic         hreset, hwrite, hready;
   logic [31:0]  haddr, hwdata;
   logic         hreadyout;
   logic [31:0]  hrdata, data_read_loc, data_write_loc, size_data;
   logic [127:0] key;
   logic [1:0]   flag;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model: eight 32-bit words plus the one pending transfer.
   logic [31:0] m_regs [8];
   logic [31:0] m_paddr;
   logic        m_pwrite;

   ahb_slave_2 #(.BASE_ADDR(BASE)) dut (
      .hclk(hclk), .hreset(hreset), .haddr(haddr), .hwrite(hwrite),
      .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
      .hrdata(hrdata), .data_read_loc(data_read_loc),
      .data_write_loc(data_write_loc), .key(key), .size_data(size_data),
      .flag(flag)
   );

   always #5 hclk = ~hclk;

   function automatic bit m_mapped(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return (o < 32'd32) && (o[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] m_read();
      int k;
      if (m_pwrite || !m_mapped(m_paddr)) return 32'h0;
      k = int'((m_paddr - BASE) >> 2);
`ifdef AHB_SLAVE_KEY_READ_MASK_EN
      if (k >= 2 && k <= 5) return 32'h0;
`endif
      return m_regs[k];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic hr, input logic [31:0] a, input logic w,
                             input logic rdy, input logic [31:0] wd);
      int k;
      if (hr) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
         m_paddr  = 32'h0;
         m_pwrite = 1'b0;
      end else if (rdy) begin
         if (m_pwrite && m_mapped(m_paddr)) begin
            k = int'((m_paddr - BASE) >> 2);
            m_regs[k] = (k == 7) ? (wd & 32'h3) : wd;
         end
         m_paddr  = a;
         m_pwrite = w;
      end
   endtask

   // Drive one bus cycle, step the model on the edge, return just after it.
   task automatic cycle(input logic hr, input logic [31:0] a, input logic w,
                        input logic rdy, input logic [31:0] wd);
      hreset = hr; haddr = a; hwrite = w; hready = rdy; hwdata = wd;
      @(posedge hclk);
      model_edge(hr, a, w, rdy, wd);
      #1;
   endtask

   task automatic do_reset();
      cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
      cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
   endtask

   // Address cycle, data cycle, one idle cycle.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(1'b0, a, 1'b1, 1'b1, 32'h0);
      cycle(1'b0, 32'h0000_0100, 1'b0, 1'b1, d);
      cycle(1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge hclk) begin
      if (chk_en) begin
         check("hreadyout", {127'h0, hreadyout}, 128'h1);
         check("data_read_loc", {96'h0, data_read_loc}, {96'h0, m_regs[0]});
         check("data_write_loc", {96'h0, data_write_loc}, {96'h0, m_regs[1]});
         check("key", key, {m_regs[2], m_regs[3], m_regs[4], m_regs[5]});
         check("size_data", {96'h0, size_data}, {96'h0, m_regs[6]});
         check("flag", {126'h0, flag}, {96'h0, m_regs[7]});
         check("hrdata", {96'h0, hrdata}, {96'h0, m_read()});
      end
   end

   initial begin
      logic [31:0] a, exp_flag [4], wdat [4];
      int sel;
      exp_flag[0] = 32'h1; exp_flag[1] = 32'h0; exp_flag[2] = 32'h2; exp_flag[3] = 32'h3;
      wdat[0] = 32'h5; wdat[1] = 32'h4; wdat[2] = 32'h6; wdat[3] = 32'h7;
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_paddr = 32'h0; m_pwrite = 1'b0;

      do_reset();
      chk_en = 1'b1;
      check("rst_key", key, 128'h0);
      check("rst_hrdata", {96'h0, hrdata}, 128'h0);

      wr(BASE + 32'h00, 32'h2);
      check("tp_rdloc", {96'h0, data_read_loc}, 128'h2);
      check("tp_others", {data_write_loc, size_data, 30'h0, flag, 32'h0}, 128'h0);
      check("tp_key0", key, 128'h0);

      wr(BASE + 32'h04, 32'h6);
      check("tp_wrloc", {96'h0, data_write_loc}, 128'h6);
      wr(BASE + 32'h08, 32'h7);
      wr(BASE + 32'h0C, 32'h5);
      wr(BASE + 32'h10, 32'h3);
      wr(BASE + 32'h14, 32'h6);
      check("tp_key", key, {32'h7, 32'h5, 32'h3, 32'h6});
      wr(BASE + 32'h18, 32'h5);
      check("tp_size", {96'h0, size_data}, 128'h5);

      for (int i = 0; i < 4; i++) begin
         do_reset();
         wr(BASE + 32'h1C, wdat[i]);
         check("tp_flag", {126'h0, flag}, {96'h0, exp_flag[i]});
      end

      do_reset();
      wr(BASE + 32'h21C, 32'h7);
      check("tp_unmapped_flag", {126'h0, flag}, 128'h0);
      check("tp_unmapped_regs", {data_read_loc, data_write_loc, size_data, 32'h0}, 128'h0);
      cycle(1'b0, BASE + 32'h21C, 1'b0, 1'b1, 32'h0);
      check("tp_unmapped_read", {96'h0, hrdata}, 128'h0);

      // Write to flag, reset arrives on the data-phase edge.
      cycle(1'b0, BASE + 32'h1C, 1'b1, 1'b1, 32'h0);
      cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h1);
      check("tp_rst_flag", {126'h0, flag}, 128'h0);

      wr(BASE + 32'h00, 32'hABCD);
      cycle(1'b0, BASE + 32'h00, 1'b0, 1'b1, 32'h0);
      check("tp_readback", {96'h0, hrdata}, 128'hABCD);
      check("tp_hreadyout", {127'h0, hreadyout}, 128'h1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      a = BASE + 32'd4 * $urandom_range(0, 7);
         else if (sel < 8) a = BASE + $urandom_range(0, 63);
         else              a = ($urandom & 32'hFFFF_FFE0) | (32'd4 * $urandom_range(0, 7));
         cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, a, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, $urandom);
      end

      @(negedge hclk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
